// File: rtl/mem_load_queue.sv
// rtl/mem_load_queue.sv - in-order load result queue with alignment, flush cancel and writeback handshake
//
// Ports:
//   clk_i, reset_i                   clock, asynchronous active-high reset
//   req_valid_i/req_ready_o          load issue (op, byte offset, destination register)
//   resp_data_ok_i, resp_rdata_i     in-order data-bus response beats
//   flush_i                          cancel every queued load
//   out_valid_o/out_ready_i          writeback handshake with aligned data, byte strobes, destination
//   busy_o                           entries or cancelled responses still outstanding
module mem_load_queue #(
  parameter int DEPTH  = 4,
  parameter int DEST_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  input  logic [2:0]        req_op_i,
  input  logic [1:0]        req_addr_lo_i,
  input  logic [DEST_W-1:0] req_dest_i,
  output logic              req_ready_o,
  input  logic              resp_data_ok_i,
  input  logic [31:0]       resp_rdata_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic [3:0]        out_strb_o,
  output logic [DEST_W-1:0] out_dest_o,
  output logic              busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = CW + 2;

  logic [2:0]        op_q   [DEPTH];
  logic [2:0]        op_d   [DEPTH];
  logic [1:0]        addr_q [DEPTH];
  logic [1:0]        addr_d [DEPTH];
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [DEST_W-1:0] dest_d [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     alloc_q, alloc_d, fill_q, fill_d, ret_q, ret_d;
  logic [CW-1:0]     count_q, count_d, cancel_q, cancel_d;

  logic [CW-1:0] filled, unfilled;
  logic [TW-1:0] cancel_sum;
  logic          req_acc, resp_fill, head_vld, bypass, retire;
  logic [31:0]   word, ext_data;
  logic [3:0]    ext_strb;
  logic [2:0]    hop;
  logic [1:0]    hoff;
  logic [7:0]    hbyte;
  logic [15:0]   hhalf;

  // data_vld is only ever set on allocated entries, so the popcount is the
  // number of filled entries and the rest of count is still awaiting data.
  always_comb begin
    filled = '0;
    for (int i = 0; i < DEPTH; i++) filled = filled + CW'(vld_q[i]);
    unfilled = count_q - filled;
  end

  assign req_ready_o = ({1'b0, count_q} + {1'b0, cancel_q}) < (CW + 1)'(DEPTH);
  assign req_acc     = req_valid_i && req_ready_o;
  assign resp_fill   = resp_data_ok_i && (cancel_q == '0) && (unfilled != '0);
  assign head_vld    = vld_q[ret_q];
  assign bypass      = resp_fill && (fill_q == ret_q);
  assign out_valid_o = (head_vld || bypass) && (cancel_q == '0) && !flush_i;
  assign retire      = out_valid_o && out_ready_i;
  assign busy_o      = (count_q != '0) || (cancel_q != '0);

  // Responses still owed after a flush: already owed + unfilled entries +
  // the load issued this cycle, minus a response arriving this cycle.
  always_comb begin
    cancel_sum = TW'(cancel_q) + TW'(unfilled) + TW'(req_acc);
    if (resp_data_ok_i && cancel_sum != '0) cancel_sum = cancel_sum - TW'(1);
  end

  always_comb begin
    op_d     = op_q;
    addr_d   = addr_q;
    dest_d   = dest_q;
    data_d   = data_q;
    vld_d    = vld_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    ret_d    = ret_q;
    count_d  = count_q;
    cancel_d = cancel_q;
    if (flush_i) begin
      vld_d    = '0;
      alloc_d  = '0;
      fill_d   = '0;
      ret_d    = '0;
      count_d  = '0;
      cancel_d = CW'(cancel_sum);
    end else begin
      if (resp_data_ok_i && cancel_q != '0) cancel_d = cancel_q - CW'(1);
      if (resp_fill) begin
        data_d[fill_q] = resp_rdata_i;
        vld_d[fill_q]  = 1'b1;
        fill_d         = fill_q + PW'(1);
      end
      // Placed after the fill so a bypassed head is cleared, not left valid.
      if (retire) begin
        vld_d[ret_q] = 1'b0;
        ret_d        = ret_q + PW'(1);
      end
      if (req_acc) begin
        op_d[alloc_q]   = req_op_i;
        addr_d[alloc_q] = req_addr_lo_i;
        dest_d[alloc_q] = req_dest_i;
        vld_d[alloc_q]  = 1'b0;
        alloc_d         = alloc_q + PW'(1);
      end
      count_d = count_q + CW'(req_acc) - CW'(retire);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        addr_q[i] <= '0;
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q    <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      ret_q    <= '0;
      count_q  <= '0;
      cancel_q <= '0;
    end else begin
      op_q     <= op_d;
      addr_q   <= addr_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      ret_q    <= ret_d;
      count_q  <= count_d;
      cancel_q <= cancel_d;
    end
  end

  // Alignment of the head word; the word comes from the response bus when bypassing.
  always_comb begin
    word = head_vld ? data_q[ret_q] : resp_rdata_i;
    hop  = op_q[ret_q];
    hoff = addr_q[ret_q];
    case (hoff)
      2'd0:    hbyte = word[7:0];
      2'd1:    hbyte = word[15:8];
      2'd2:    hbyte = word[23:16];
      default: hbyte = word[31:24];
    endcase
    hhalf    = hoff[1] ? word[31:16] : word[15:0];
    ext_data = word;
    ext_strb = 4'hf;
    case (hop)
      3'd0: ext_data = {{24{hbyte[7]}}, hbyte};
      3'd1: ext_data = {24'b0, hbyte};
      3'd2: ext_data = {{16{hhalf[15]}}, hhalf};
      3'd3: ext_data = {16'b0, hhalf};
      3'd5: begin
        ext_data = word << {~hoff, 3'b000};
        ext_strb = 4'hf << ~hoff;
      end
      3'd6: begin
        ext_data = word >> {hoff, 3'b000};
        ext_strb = 4'hf >> hoff;
      end
      default: begin
        ext_data = word;
        ext_strb = 4'hf;
      end
    endcase
  end

  assign out_data_o = out_valid_o ? ext_data : '0;
  assign out_strb_o = out_valid_o ? ext_strb : '0;
  assign out_dest_o = out_valid_o ? dest_q[ret_q] : '0;

endmodule

// File: tb/tb_mem_load_queue.sv
// tb/tb_mem_load_queue.sv - directed and random checks of mem_load_queue against a queue-based model
module tb_mem_load_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [1:0]  req_addr_lo;
  logic [4:0]  req_dest;
  logic        req_ready;
  logic        resp_data_ok;
  logic [31:0] resp_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic [4:0]  out_dest;
  logic        busy;

  always #5 clk = ~clk;

  mem_load_queue #(.DEPTH(DEPTH), .DEST_W(5)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_addr_lo_i(req_addr_lo),
    .req_dest_i(req_dest), .req_ready_o(req_ready),
    .resp_data_ok_i(resp_data_ok), .resp_rdata_i(resp_rdata), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_strb_o(out_strb), .out_dest_o(out_dest),
    .busy_o(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [4:0]  dest;
    logic [31:0] data;
    bit          vld;
  } ent_t;

  ent_t mq[$];
  int   mcancel = 0;
  int   compared = 0;
  int   mismatched = 0;

  // values captured at the check point, applied to the model after the edge
  bit          s_acc, s_ret, s_rsp, s_fl;
  int          s_fill_idx;
  logic [31:0] s_rd;
  logic [2:0]  s_op;
  logic [1:0]  s_off;
  logic [4:0]  s_dest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_ext(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w,
                                    output logic [31:0] d, output logic [3:0] s);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    d = w;
    s = 4'b1111;
    case (op)
      3'd0: d = {{24{b[7]}}, b};
      3'd1: d = {24'b0, b};
      3'd2: d = {{16{h[15]}}, h};
      3'd3: d = {16'b0, h};
      3'd5: case (off)
        2'd0: begin d = {w[7:0], 24'b0};  s = 4'b1000; end
        2'd1: begin d = {w[15:0], 16'b0}; s = 4'b1100; end
        2'd2: begin d = {w[23:0], 8'b0};  s = 4'b1110; end
        default: begin d = w; s = 4'b1111; end
      endcase
      3'd6: case (off)
        2'd0: begin d = w;                 s = 4'b1111; end
        2'd1: begin d = {8'b0, w[31:8]};   s = 4'b0111; end
        2'd2: begin d = {16'b0, w[31:16]}; s = 4'b0011; end
        default: begin d = {24'b0, w[31:24]}; s = 4'b0001; end
      endcase
      default: ;
    endcase
  endfunction

  // Apply inputs at the falling edge, then check the model's expectations.
  task automatic drive(input bit rv, input logic [2:0] op, input logic [1:0] off, input logic [4:0] dst,
                       input bit rsp, input logic [31:0] rd, input bit fl, input bit ordy);
    bit          e_ready, e_valid, e_busy;
    logic [31:0] w, e_data;
    logic [3:0]  e_strb;
    req_valid = rv; req_op = op; req_addr_lo = off; req_dest = dst;
    resp_data_ok = rsp; resp_rdata = rd; flush = fl; out_ready = ordy;
    #1;
    e_ready = (mq.size() + mcancel) < DEPTH;
    e_busy  = (mq.size() != 0) || (mcancel != 0);
    s_fill_idx = -1;
    if (rsp && mcancel == 0)
      for (int i = 0; i < mq.size(); i++)
        if (!mq[i].vld) begin s_fill_idx = i; break; end
    e_valid = 1'b0;
    w = rd;
    if (mq.size() > 0 && mcancel == 0 && !fl) begin
      if (mq[0].vld) begin e_valid = 1'b1; w = mq[0].data; end
      else if (s_fill_idx == 0) e_valid = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(e_busy));
    if (e_valid) begin
      model_ext(mq[0].op, mq[0].off, w, e_data, e_strb);
      chk("out_data", out_data, e_data);
      chk("out_strb", 32'(out_strb), 32'(e_strb));
      chk("out_dest", 32'(out_dest), 32'(mq[0].dest));
    end
    s_acc = rv && e_ready; s_ret = e_valid && ordy; s_rsp = rsp; s_fl = fl;
    s_rd = rd; s_op = op; s_off = off; s_dest = dst;
  endtask

  task automatic adv();
    ent_t e;
    int   unf, tmp;
    @(posedge clk);
    if (s_fl) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].vld) unf++;
      tmp = mcancel + unf + int'(s_acc) - int'(s_rsp);
      mcancel = (tmp < 0) ? 0 : tmp;
      mq.delete();
    end else begin
      if (s_rsp && mcancel > 0) mcancel--;
      else if (s_fill_idx >= 0) begin
        mq[s_fill_idx].vld  = 1'b1;
        mq[s_fill_idx].data = s_rd;
      end
      if (s_ret) void'(mq.pop_front());
      if (s_acc) begin
        e.op = s_op; e.off = s_off; e.dest = s_dest; e.data = '0; e.vld = 1'b0;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    drive(0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 0, ordy);
    adv();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_op = 0; req_addr_lo = 0; req_dest = 0;
    resp_data_ok = 0; resp_rdata = 0; flush = 0; out_ready = 0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_strb", 32'(out_strb), 32'd0);
    chk("rst_dest", 32'(out_dest), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LB offset 3 with same-cycle bypass retire
    drive(1, 3'd0, 2'd3, 5'd7, 0, 32'd0, 0, 1); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'h80112233, 0, 1);
    chk("lb_bypass_valid", 32'(out_valid), 32'd1);
    chk("lb_bypass_data", out_data, 32'hFFFFFF80);
    chk("lb_bypass_dest", 32'(out_dest), 32'd7);
    adv();

    // LWL offset 1 then LWR offset 2
    drive(1, 3'd5, 2'd1, 5'd1, 0, 32'd0, 0, 0); adv();
    drive(1, 3'd6, 2'd2, 5'd2, 0, 32'd0, 0, 0); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'hAABBCCDD, 0, 1);
    chk("lwl_data", out_data, 32'hCCDD0000);
    chk("lwl_strb", 32'(out_strb), 32'hC);
    adv();
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'h11223344, 0, 1);
    chk("lwr_data", out_data, 32'h00001122);
    chk("lwr_strb", 32'(out_strb), 32'h3);
    adv();

    // fill the queue, then one response with retire frees a slot
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 3'd4, 2'd0, 5'(i + 3), 0, 32'd0, 0, 0); adv();
    end
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'h01020304, 0, 1);
    chk("full_ready", 32'(req_ready), 32'd0);
    adv();
    idle(0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 3'd0, 2'd0, 5'd0, 1, $urandom, 0, 1); adv();
    end

    // flush with 2 unfilled entries and a concurrent load
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd3, 2'd2, 5'(i + 10), 0, 32'd0, 0, 0); adv();
    end
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'h5566_7788, 0, 0); adv();
    drive(1, 3'd2, 2'd0, 5'd20, 0, 32'd0, 1, 1); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 0, 1);
    chk("flush_busy", 32'(busy), 32'd1);
    adv();
    drive(1, 3'd1, 2'd1, 5'd21, 1, 32'hDEAD0001, 0, 1); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'hDEAD0002, 0, 1); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'hDEAD0003, 0, 1); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'h0000A500, 0, 1);
    chk("post_flush_data", out_data, 32'h000000A5);
    adv();

    // two filled entries held for 5 cycles, then wrap with load/retire pairs
    drive(1, 3'd4, 2'd0, 5'd4, 0, 32'd0, 0, 0); adv();
    drive(1, 3'd2, 2'd2, 5'd5, 1, 32'h12345678, 0, 0); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 1, 32'h9ABCDEF0, 0, 0); adv();
    for (int i = 0; i < 5; i++) idle(0);
    idle(1); idle(1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'($urandom_range(0, 7)), 2'($urandom), 5'($urandom), 0, 32'd0, 0, 1); adv();
      drive(0, 3'd0, 2'd0, 5'd0, 1, $urandom, 0, 1); adv();
    end

    // asynchronous reset mid-cycle with 2 pending (one filled)
    drive(1, 3'd4, 2'd0, 5'd9, 0, 32'd0, 0, 0); adv();
    drive(1, 3'd4, 2'd0, 5'd8, 1, 32'hCAFEF00D, 0, 0); adv();
    drive(0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_strb", 32'(out_strb), 32'd0);
    chk("arst_dest", 32'(out_dest), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    mq.delete();
    mcancel = 0;
    @(negedge clk);
    reset = 1'b0;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 99) < 55, 3'($urandom_range(0, 7)), 2'($urandom), 5'($urandom),
            $urandom_range(0, 99) < 50, $urandom, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 70);
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_load_queue.md
MEM_LOAD_QUEUE -- requirements
Module: mem_load_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set max in-flight loads (power of 2, >=2).
REQ-002 Parameter DEST_W, default 5, SHALL set destination-register tag width.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; SHALL clear all state immediately.
REQ-005 req_valid  in  1  load issued on data bus this cycle (address handshake done).
REQ-006 req_op  in  3  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR; 7 reserved, treated as LW.
REQ-007 req_addr_lo  in  2  byte offset of the load address.
REQ-008 req_dest  in  DEST_W  destination register.
REQ-009 req_ready  out  1  a new load may be issued.
REQ-010 resp_data_ok  in  1  in-order data-bus response beat.
REQ-011 resp_rdata  in  32  response word.
REQ-012 flush  in  1  exception/eret cancel of all queued loads.
REQ-013 out_valid  out  1, out_ready  in  1  writeback handshake.
REQ-014 out_data  out  32, out_strb  out  4, out_dest  out  DEST_W  aligned result, byte write-enables, destination.
REQ-015 busy  out  1  any entry or cancelled response outstanding.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular queue {op, addr_lo, dest, data, data_vld} with alloc, fill and retire pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 count = allocated entries; cancel_cnt (log2(DEPTH)+1 bits) = responses still owed to flushed loads.
REQ-018 req_ready SHALL be (count + cancel_cnt < DEPTH); req_valid while !req_ready is illegal, SHALL be ignored.
REQ-019 Accepted req_valid SHALL allocate at the alloc pointer with data_vld=0.
REQ-020 resp_data_ok with cancel_cnt>0 SHALL decrement cancel_cnt and discard resp_rdata.
REQ-021 resp_data_ok with cancel_cnt=0 SHALL write the fill-pointer entry, set data_vld, advance fill pointer; with no pending entry it is illegal and SHALL be ignored.
REQ-022 out_valid SHALL be 1 when the head has data_vld, or combinationally when resp_data_ok fills the head this cycle (zero-latency bypass, data from resp_rdata).
REQ-023 out_valid && out_ready SHALL retire the head; alloc and retire in the same cycle SHALL keep count unchanged.
REQ-024 Extraction: LB/LBU select byte addr_lo, LH/LHU halfword addr_lo[1], sign-extend LB/LH, zero-extend LBU/LHU; LW whole word.
REQ-025 LWL off 0/1/2/3: data {w[7:0],24'b0}/{w[15:0],16'b0}/{w[23:0],8'b0}/w, strb 1000/1100/1110/1111.
REQ-026 LWR off 0/1/2/3: data w/{8'b0,w[31:8]}/{16'b0,w[31:16]}/{24'b0,w[31:24]}, strb 1111/0111/0011/0001.
REQ-027 Other ops: out_strb = 1111.
REQ-028 out_valid SHALL be 0 when cancel_cnt>0 or flush is high.
REQ-029 flush SHALL empty the queue next cycle; cancel_cnt_next = cancel_cnt + (entries without data_vld) + req_valid - resp_data_ok, never below 0.
REQ-030 flush same cycle as out_ready SHALL not retire (out_valid already 0).
REQ-031 busy = (count != 0) || (cancel_cnt != 0).

Reset
REQ-032 During/after reset: count=0, cancel_cnt=0, all pointers=0, all data_vld=0, req_ready=1, out_valid=0, out_data=0, out_strb=0, out_dest=0, busy=0.
REQ-033 Reset asserted mid-operation SHALL drop all entries and owed responses without producing out_valid.

Verification
REQ-034 LB addr_lo=3 dest=7, resp 0x80112233 same cycle out_ready=1 -> out_valid that cycle, out_data=0xFFFFFF80, strb 1111, dest 7.
REQ-035 LWL off 1 then LWR off 2, responses 0xAABBCCDD, 0x11223344 -> 0xCCDD0000/1100 then 0x00001122/0011, in order.
REQ-036 Issue 4 loads (DEPTH=4), no responses -> req_ready=0; one response + retire -> req_ready=1 next cycle.
REQ-037 3 loads, 1 response, flush with concurrent req_valid -> cancel_cnt=3, busy=1; next 3 responses discarded, then new load's response delivered.
REQ-038 out_ready=0 for 5 cycles with 2 filled entries -> out_data stable, no loss; pointers wrap across 6 load/retire pairs with correct order.
REQ-039 Reset asserted asynchronously mid-cycle with 2 pending -> outputs per REQ-032 before next edge.
